// File: rtl/r200_pkg.sv
`default_nettype none
// ============================================================================
// Module      : r200_pkg
// Description : Shared definitions for the r200 data-memory responder.
//               RV32I load/store func3 encodings and the responder FSM
//               state type.
// Revision    : 1.0  initial release
// ============================================================================
package r200_pkg;

    // RV32I load/store access size/sign encodings (instruction func3 field)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage : r200_pkg
`default_nettype wire

// File: rtl/r200_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : r200_lsu_align
// Description : Combinational load/store lane alignment for the r200 data
//               memory. Generates byte enables and lane-shifted store data,
//               extracts and sign/zero-extends load data, and classifies
//               func3 legality and misalignment.
//               Build option: R200_MISALIGN_TRAP_EN -- when defined,
//               misaligned halfword/word accesses raise misalign_fault;
//               when undefined misalign_fault is tied low and the low
//               address bits below the access size are simply ignored.
// Ports       : func3          access size/sign (RV32I encoding)
//               addr_lo        byte offset within the word (addr[1:0])
//               wdata          right-aligned store data
//               rword          full RAM word read at the target index
//               byte_en        per-lane write enables
//               wlanes         store data moved to its byte lanes
//               load_data      extracted, extended load result
//               load_f3_ok     func3 is a legal load encoding
//               store_f3_ok    func3 is a legal store encoding
//               misalign_fault access is misaligned and trapping is enabled
// Revision    : 1.0  initial release
// ============================================================================
module r200_lsu_align
    import r200_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wlanes,
    output logic [31:0] load_data,
    output logic        load_f3_ok,
    output logic        store_f3_ok,
    output logic        misalign_fault
);

    logic [1:0]  w_off;     // effective lane offset after size alignment
    logic [4:0]  w_shift;   // w_off expressed in bits
    logic [31:0] w_rshift;  // RAM word with the selected lane at bit 0

    // Offset: bytes use both low bits, halves only addr[1], words lane 0.
    always_comb begin
        w_off = 2'b00;
        case (func3[1:0])
            2'b00:   w_off = addr_lo;
            2'b01:   w_off = {addr_lo[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

    assign w_shift  = {w_off, 3'b000};
    assign wlanes   = wdata << w_shift;
    assign w_rshift = rword >> w_shift;

    always_comb begin
        byte_en = 4'b0000;
        case (func3[1:0])
            2'b00:   byte_en = 4'b0001 << w_off;
            2'b01:   byte_en = 4'b0011 << w_off;
            default: byte_en = 4'b1111;
        endcase
    end

    always_comb begin
        load_data = w_rshift;
        case (func3)
            F3_B:    load_data = {{24{w_rshift[7]}},  w_rshift[7:0]};
            F3_BU:   load_data = {24'h000000,         w_rshift[7:0]};
            F3_H:    load_data = {{16{w_rshift[15]}}, w_rshift[15:0]};
            F3_HU:   load_data = {16'h0000,           w_rshift[15:0]};
            default: load_data = w_rshift;
        endcase
    end

    assign load_f3_ok  = (func3 == F3_B)  || (func3 == F3_H)  || (func3 == F3_W) ||
                         (func3 == F3_BU) || (func3 == F3_HU);
    assign store_f3_ok = (func3 == F3_B)  || (func3 == F3_H)  || (func3 == F3_W);

`ifdef R200_MISALIGN_TRAP_EN
    assign misalign_fault = ((func3[1:0] == 2'b01) && addr_lo[0]) ||
                            ((func3[1:0] == 2'b10) && (addr_lo != 2'b00));
`else
    assign misalign_fault = 1'b0;
`endif

endmodule : r200_lsu_align
`default_nettype wire

// File: rtl/r200_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : r200_dmem_resp
// Description : Data-memory responder for the r200 MEM stage. Accepts one
//               load/store request per valid/ready handshake, accesses an
//               internal word-addressed RAM on the accept edge, optionally
//               inserts WAIT_CYCLES wait states, then holds a response
//               until the requester takes it.
//               Build option: R200_MISALIGN_TRAP_EN -- misaligned half/word
//               accesses fault instead of being silently aligned down.
// Parameters  : DEPTH       RAM size in 32-bit words (power of two, >= 2)
//               WAIT_CYCLES wait states between accept and response (0..15)
// Ports       : clk, rst               clock, synchronous active-high reset
//               req_valid / req_ready  request handshake
//               req_we                 1 = store, 0 = load
//               req_func3              RV32I access size/sign
//               req_addr               byte address
//               req_wdata              right-aligned store data
//               resp_valid / resp_ready response handshake
//               resp_rdata             extended load data (0 for stores/faults)
//               resp_err               access fault
// Revision    : 1.0  initial release
// ============================================================================
module r200_dmem_resp
    import r200_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         c_aw        = $clog2(DEPTH);
    localparam logic [3:0] c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [31:0] r_mem [DEPTH];

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_rdata;
    logic        r_err;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic            w_accept;
    logic [c_aw-1:0] w_word_idx;
    logic            w_out_of_range;
    logic [31:0]     w_rword;
    logic [3:0]      w_byte_en;
    logic [31:0]     w_wlanes;
    logic [31:0]     w_load_data;
    logic            w_load_f3_ok;
    logic            w_store_f3_ok;
    logic            w_misalign_fault;
    logic            w_err;

    // Ready is suppressed during reset so nothing is accepted on a reset edge.
    assign req_ready  = (r_state == ST_IDLE) && !rst;
    assign resp_valid = (r_state == ST_RESP);
    assign w_accept   = req_ready && req_valid;

    assign w_word_idx     = req_addr[c_aw+1:2];
    assign w_out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
    assign w_rword        = r_mem[w_word_idx];

    r200_lsu_align u_align (
        .func3          (req_func3),
        .addr_lo        (req_addr[1:0]),
        .wdata          (req_wdata),
        .rword          (w_rword),
        .byte_en        (w_byte_en),
        .wlanes         (w_wlanes),
        .load_data      (w_load_data),
        .load_f3_ok     (w_load_f3_ok),
        .store_f3_ok    (w_store_f3_ok),
        .misalign_fault (w_misalign_fault)
    );

    assign w_err = w_out_of_range ||
                   (req_we ? !w_store_f3_ok : !w_load_f3_ok) ||
                   w_misalign_fault;

    // ------------------------------------------------------------------
    // RAM write: commits on the accept edge. Not reset, so a store that was
    // already accepted survives a later reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byte_en[b]) begin
                    r_mem[w_word_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response capture: load data and fault status are frozen at accept
    // and held unchanged until the response handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_err   <= w_err;
            r_rdata <= (req_we || w_err) ? 32'd0 : w_load_data;
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES > 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_wait_load;
                    end else begin
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // Counter is loaded with WAIT_CYCLES-1, so exit on zero.
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule : r200_dmem_resp
`default_nettype wire
